// File: rtl/uart_pkg.sv
// Shared definitions for the UART line buffer: control characters and FSM states.
package uart_pkg;

  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_BS  = 8'h08;
  localparam logic [7:0] CHAR_DEL = 8'h7F;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    SEND_CR = 2'd2,
    SEND_LF = 2'd3
  } state_e;

  // True for bytes that edit the line rather than being stored in it.
  function automatic logic is_control(input logic [7:0] b);
    return (b == CHAR_CR) || (b == CHAR_LF) || (b == CHAR_BS) || (b == CHAR_DEL);
  endfunction

endpackage

// File: rtl/uart_line_ram.sv
// Line storage: DEPTH x 8, synchronous write, asynchronous read, no reset.
module uart_line_ram #(
  parameter int DEPTH = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [7:0]               wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [7:0]               rdata_o
);

  logic [7:0] mem_q [DEPTH];

  // Capture the written byte; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_line_buffer.sv
// Line editor between UART RX and TX: collects a line with backspace editing,
// then replays it followed by CR LF. A full line is flushed automatically.
module uart_line_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                   uart_clk,
  input  logic                   uart_rst_n,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] line_len,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  state_e          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  logic            alive_q;

  logic            in_xfer;
  logic            out_xfer;
  logic            is_store;
  logic            is_erase;
  logic            last_byte;
  logic            fills_line;
  logic [7:0]      ram_rdata;

  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = out_valid && out_ready;
  assign is_store   = !is_control(in_data);
  assign is_erase   = (in_data == CHAR_BS) || (in_data == CHAR_DEL);
  assign last_byte  = ({1'b0, rd_ptr_q} == (len_q - LW'(1)));
  assign fills_line = (len_q == LW'(DEPTH - 1));

  uart_line_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (uart_clk),
    .we_i    (in_xfer && is_store),
    .waddr_i (len_q[AW-1:0]),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // State register; alive_q holds in_ready low until the first edge after reset.
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      state_q <= COLLECT;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
    end
  end

  // Next-state logic: CR or a full line ends collection, CR/LF close the output.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: begin
        if (in_xfer) begin
          if (in_data == CHAR_CR) begin
            state_d = (len_q != '0) ? DRAIN : SEND_CR;
          end else if (is_store && fills_line) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN:   if (out_xfer && last_byte) state_d = SEND_CR;
      SEND_CR: if (out_xfer) state_d = SEND_LF;
      SEND_LF: if (out_xfer) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Line length, read pointer and overflow pulse updates.
  always_comb begin
    len_d    = len_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = 1'b0;
    case (state_q)
      COLLECT: begin
        // Keeping rd_ptr at zero here guarantees DRAIN starts at buf[0].
        rd_ptr_d = '0;
        if (in_xfer) begin
          if (is_erase) begin
            if (len_q != '0) len_d = len_q - LW'(1);
          end else if (is_store) begin
            len_d = len_q + LW'(1);
            ovf_d = fills_line;
          end
        end
      end
      DRAIN: begin
        if (out_xfer) rd_ptr_d = rd_ptr_q + AW'(1);
      end
      SEND_LF: begin
        if (out_xfer) begin
          len_d    = '0;
          rd_ptr_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset abandons any line in progress.
  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      len_q    <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      len_q    <= len_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Outputs decoded from state: input side open only while collecting.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    case (state_q)
      COLLECT: in_ready = alive_q;
      DRAIN: begin
        out_valid = 1'b1;
        out_data  = ram_rdata;
      end
      SEND_CR: begin
        out_valid = 1'b1;
        out_data  = CHAR_CR;
      end
      SEND_LF: begin
        out_valid = 1'b1;
        out_data  = CHAR_LF;
      end
      default: ;
    endcase
  end

  assign line_len = len_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_line_buffer.sv
// Bench for uart_line_buffer: a 32-byte and a 4-byte instance share stimulus,
// one selected at a time, against a queue-based model of the line editor.
module tb_uart_line_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;
  logic        sel4;

  logic        ir32, ov32, of32;
  logic [7:0]  od32;
  logic [5:0]  ll32;
  logic        ir4, ov4, of4;
  logic [7:0]  od4;
  logic [2:0]  ll4;

  logic        obs_ir, obs_ov, obs_of;
  logic [7:0]  obs_od;
  logic [31:0] obs_len;

  int          n_cmp;
  int          n_bad;

  byte unsigned line_m[$];
  byte unsigned exp_q[$];
  bit          alive_m;
  bit          ovf_m;
  int          depth_m;

  always #5 clk = ~clk;

  uart_line_buffer #(.DEPTH(32)) u_dut32 (
    .uart_clk   (clk),
    .uart_rst_n (rst_n),
    .in_valid   (in_valid & ~sel4),
    .in_data    (in_data),
    .in_ready   (ir32),
    .out_valid  (ov32),
    .out_data   (od32),
    .out_ready  (out_ready & ~sel4),
    .line_len   (ll32),
    .overflow   (of32)
  );

  uart_line_buffer #(.DEPTH(4)) u_dut4 (
    .uart_clk   (clk),
    .uart_rst_n (rst_n),
    .in_valid   (in_valid & sel4),
    .in_data    (in_data),
    .in_ready   (ir4),
    .out_valid  (ov4),
    .out_data   (od4),
    .out_ready  (out_ready & sel4),
    .line_len   (ll4),
    .overflow   (of4)
  );

  assign obs_ir  = sel4 ? ir4 : ir32;
  assign obs_ov  = sel4 ? ov4 : ov32;
  assign obs_of  = sel4 ? of4 : of32;
  assign obs_od  = sel4 ? od4 : od32;
  assign obs_len = sel4 ? 32'(ll4) : 32'(ll32);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: apply one accepted input byte to the line being collected.
  function automatic void accept(input byte unsigned b);
    if (b == 8'h0D) begin
      exp_q = line_m;
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end else if (b == 8'h0A) begin
      // line feeds from the receiver are dropped
    end else if (b == 8'h08 || b == 8'h7F) begin
      if (line_m.size() > 0) void'(line_m.pop_back());
    end else begin
      line_m.push_back(b);
      if (line_m.size() == depth_m) begin
        exp_q = line_m;
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        ovf_m = 1'b1;
      end
    end
  endfunction

  // One clock: drive after the edge, check on the falling edge, advance model.
  task automatic step(input bit v, input logic [7:0] d, input bit r);
    bit exp_ir;
    bit exp_ov;
    @(posedge clk);
    if (rst_n) alive_m = 1'b1;
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    exp_ir = alive_m && (exp_q.size() == 0);
    exp_ov = (exp_q.size() != 0);
    check("in_ready", obs_ir, exp_ir);
    check("out_valid", obs_ov, exp_ov);
    check("line_len", obs_len, line_m.size());
    check("overflow", obs_of, ovf_m);
    if (exp_ov) check("out_data", obs_od, exp_q[0]);
    ovf_m = 1'b0;
    if (v && exp_ir) accept(d);
    if (exp_ov && r) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) line_m.delete();
    end
  endtask

  task automatic put(input logic [7:0] b);
    step(1'b1, b, 1'b1);
  endtask

  task automatic put_str(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  // Assert reset between clock edges, check outputs drop at once, then release.
  task automatic do_reset(input bit use4);
    @(posedge clk);
    #3;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", obs_ov, 0);
    check("rst_in_ready", obs_ir, 0);
    check("rst_line_len", obs_len, 0);
    check("rst_overflow", obs_of, 0);
    sel4    = use4;
    depth_m = use4 ? 4 : 32;
    line_m.delete();
    exp_q.delete();
    ovf_m   = 1'b0;
    alive_m = 1'b0;
    #1;
    check("rst_sel_out_valid", obs_ov, 0);
    check("rst_sel_line_len", obs_len, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", obs_ir, 0);
  endtask

  function automatic logic [7:0] rnd_byte(input int cr_pct);
    int p;
    p = $urandom_range(0, 99);
    if (p < cr_pct)      return 8'h0D;
    if (p < cr_pct + 4)  return 8'h0A;
    if (p < cr_pct + 9)  return 8'h08;
    if (p < cr_pct + 12) return 8'h7F;
    return 8'($urandom_range(32, 126));
  endfunction

  task automatic run_random(input int n, input int cr_pct);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(0, 9) < 7, rnd_byte(cr_pct), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    sel4      = 1'b0;
    depth_m   = 32;
    alive_m   = 1'b0;
    ovf_m     = 1'b0;

    do_reset(1'b0);

    // "abc" CR with the transmitter always ready
    put_str("abc");
    put(8'h0D);
    idle(6);

    // backspace editing, trailing LF arrives while draining
    put_str("ab");
    put(8'h08);
    put_str("c");
    put(8'h0D);
    put(8'h0A);
    idle(6);

    // CR on an empty line, then BS and DEL on an empty line followed by CR
    put(8'h0D);
    idle(3);
    put(8'h08);
    put(8'h7F);
    put(8'h0D);
    idle(3);

    // "hi" CR with the transmitter stalling every other cycle
    put_str("hi");
    put(8'h0D);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, (i % 2) == 0);
    idle(2);

    // reset while "hello" is being replayed, then a fresh line
    put_str("hello");
    put(8'h0D);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    do_reset(1'b0);
    put_str("ok");
    put(8'h0D);
    idle(6);

    // 4-byte line: "wxyz" forces a flush; input keeps pushing during drain
    do_reset(1'b1);
    put_str("wxyz");
    for (int i = 0; i < 8; i++) step(1'b1, 8'h51, 1'b1);
    idle(8);
    run_random(600, 8);

    // 32-byte line: ordinary traffic, then rare CR so lines fill up
    do_reset(1'b0);
    run_random(1500, 8);
    run_random(1200, 1);
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_line_buffer.md
UART_LINE_BUFFER -- requirements
Module: uart_line_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 32, line buffer capacity in bytes, power of two, 4..256.
REQ-002 SHALL have port uart_clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port uart_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  in  1  byte available from the receiver (uart_rx valid).
REQ-005 SHALL have port in_data  in  8  received byte.
REQ-006 SHALL have port in_ready  out  1  byte accepted when in_valid and in_ready are both high in a cycle.
REQ-007 SHALL have port out_valid  out  1  byte offered to the transmitter (uart_tx valid).
REQ-008 SHALL have port out_data  out  8  byte offered.
REQ-009 SHALL have port out_ready  in  1  byte consumed when out_valid and out_ready are both high in a cycle.
REQ-010 SHALL have port line_len  out  $clog2(DEPTH)+1  number of bytes currently stored.
REQ-011 SHALL have port overflow  out  1  one-cycle pulse when the line is force-flushed on full.

Function
REQ-012 SHALL implement FSM states COLLECT, DRAIN, SEND_CR, SEND_LF.
REQ-013 COLLECT: in_ready=1, out_valid=0; DRAIN/SEND_CR/SEND_LF: in_ready=0, out_valid=1.
REQ-014 COLLECT, accepted 0x0D: not stored; next state DRAIN if line_len>0, else SEND_CR.
REQ-015 COLLECT, accepted 0x0A: discarded; no state change.
REQ-016 COLLECT, accepted 0x08 or 0x7F: line_len decrements if >0; no-op at 0.
REQ-017 COLLECT, any other accepted byte: written at buf[line_len]; line_len increments.
REQ-018 If that write makes line_len==DEPTH: next state DRAIN; overflow pulses high the following cycle.
REQ-019 DRAIN: out_data=buf[rd_ptr]; rd_ptr resets to 0 on DRAIN entry and increments on each transfer.
REQ-020 DRAIN: a transfer with rd_ptr==line_len-1 moves to SEND_CR.
REQ-021 SEND_CR: out_data=0x0D; a transfer moves to SEND_LF.
REQ-022 SEND_LF: out_data=0x0A; a transfer moves to COLLECT, and line_len and rd_ptr clear to 0.
REQ-023 out_valid SHALL be asserted the cycle after the terminating byte is accepted (latency 1).
REQ-024 out_data SHALL stay stable while out_valid=1 and out_ready=0; out_valid never drops without a transfer.
REQ-025 out_ready held high SHALL sustain one byte per cycle; in_valid held high in COLLECT SHALL be accepted one byte per cycle.
REQ-026 Input and output transfers SHALL be mutually exclusive by state; out_ready is ignored in COLLECT and in_valid is ignored elsewhere.
REQ-027 line_len SHALL be registered and SHALL not exceed DEPTH.

Reset
REQ-028 Reset assertion SHALL immediately force state COLLECT, line_len=0, rd_ptr=0, out_valid=0, overflow=0, in_ready=0.
REQ-029 Reset mid-DRAIN SHALL abandon the line; buffer contents need not clear.
REQ-030 in_ready SHALL rise the first clock edge after reset deassertion.

Structure
REQ-031 Shared package uart_pkg SHALL hold CHAR_CR=8'h0D, CHAR_LF=8'h0A, CHAR_BS=8'h08, CHAR_DEL=8'h7F and the state enum.
REQ-032 Storage SHALL be a sub-module uart_line_ram: DEPTH x 8, one synchronous write port, one asynchronous read port, no reset.
REQ-033 Implementation SHALL be 120-400 lines of RTL.

Verification
REQ-034 "abc",0x0D with out_ready=1 -> out 61,62,63,0D,0A on consecutive cycles starting 1 cycle after CR; line_len 3 then 0.
REQ-035 "ab",0x08,"c",0x0D,0x0A -> out 61,63,0D,0A; LF discarded; in_ready=1 at end.
REQ-036 DEPTH=4, "wxyz" -> overflow pulse, out 77,78,79,7A,0D,0A, no CR needed; in_ready=0 during drain.
REQ-037 0x0D on empty line; 0x08 on empty line then 0x0D -> out 0D,0A each time; line_len stays 0.
REQ-038 "hi",0x0D with out_ready toggling 1010... -> out_data stable while stalled, sequence 68,69,0D,0A intact.
REQ-039 Reset asserted mid-DRAIN of "hello" -> out_valid=0 immediately; after release in_ready=1, line_len=0, "ok",0x0D -> 6F,6B,0D,0A.
